// File: rtl/layer_sequencer.sv
// Layer sequencer: broadcasts one input vector to out_size nodes, pulses their start, collects each node's result.
// Optional build macro LAYER_SEQUENCER_RELU_EN clamps negative captured results to zero.

module layer_sequencer_lane #(
  parameter int bits            = 16,
  parameter int fractional_bits = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   clr,
  input  logic                   cap_en,
  input  logic                   zero_fill,
  input  logic                   ready,
  input  logic signed [bits-1:0] din,
  output logic                   hit,
  output logic                   captured,
  output logic signed [bits-1:0] dout
);
  // 0.0 in the Q(bits-fractional_bits).fractional_bits format
  localparam logic signed [bits-1:0] ZERO = bits'(0 * (1 << fractional_bits));

  logic signed [bits-1:0] din_q;

`ifdef LAYER_SEQUENCER_RELU_EN
  assign din_q = din[bits-1] ? ZERO : din;
`else
  assign din_q = din;
`endif

  // first ready wins; later or held ready on a captured node is ignored
  assign hit = cap_en & ready & ~captured;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      captured <= 1'b0;
      dout     <= '0;
    end else begin
      if (clr)      captured <= 1'b0;
      else if (hit) captured <= 1'b1;
      if (hit)                         dout <= din_q;
      else if (zero_fill && !captured) dout <= ZERO;
    end
  end
endmodule

module layer_sequencer #(
  parameter int bits            = 16,
  parameter int fractional_bits = 8,
  parameter int in_size         = 16,
  parameter int out_size        = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 start,
  input  logic signed [in_size-1:0][bits-1:0]  in_data,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic                                 node_start,
  output logic signed [in_size-1:0][bits-1:0]  node_in,
  input  logic        [out_size-1:0]           node_ready,
  input  logic signed [out_size-1:0][bits-1:0] node_out,
  output logic signed [out_size-1:0][bits-1:0] out_data
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_C = CW'(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]          state;
  logic [CW-1:0]       cnt, cnt_inc;
  logic [out_size-1:0] hit, captured;
  logic                accept, all_cap, tmo;

  assign accept  = (state == S_IDLE) & start;
  assign cnt_inc = (cnt == TO_C) ? cnt : cnt + 1'b1;
  assign all_cap = &(captured | hit);
  // completion in the same cycle as the terminal count takes priority
  assign tmo     = (state == S_WAIT) & (cnt_inc == TO_C) & ~all_cap;

  for (genvar g = 0; g < out_size; g++) begin : g_lane
    layer_sequencer_lane #(.bits(bits), .fractional_bits(fractional_bits)) u_lane (
      .clock     (clock),
      .reset_n   (reset_n),
      .clr       (accept),
      .cap_en    (state == S_WAIT),
      .zero_fill (tmo),
      .ready     (node_ready[g]),
      .din       (node_out[g]),
      .hit       (hit[g]),
      .captured  (captured[g]),
      .dout      (out_data[g])
    );
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      node_start <= 1'b0;
      node_in    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          node_in    <= in_data;
          error      <= 1'b0;
          busy       <= 1'b1;
          node_start <= 1'b1;
          state      <= S_LAUNCH;
        end
        S_LAUNCH: begin
          node_start <= 1'b0;
          cnt        <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt_inc;
          if (all_cap || tmo) begin
            error <= tmo;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_layer_sequencer.sv
// Self-checking bench for layer_sequencer: directed scenarios plus randomized ready schedules vs a schedule-level model.
module tb_layer_sequencer;
  localparam int TO = 20;

  logic              clock = 1'b0;
  logic              reset_n, start, busy, done, error, node_start;
  logic [15:0][15:0] in_data, node_in;
  logic [3:0]        node_ready;
  logic [3:0][15:0]  node_out, out_data;

  int tests = 0;
  int fails = 0;

  // per-node schedule: first ready offset after node_start (0 = never), hold length, value
  int          fr[4];
  int          hl[4];
  logic [15:0] v[4];
  int          rep_off;
  logic [15:0] rep_v;

  layer_sequencer #(.bits(16), .fractional_bits(8), .in_size(16), .out_size(4), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .in_data(in_data),
    .busy(busy), .done(done), .error(error), .node_start(node_start), .node_in(node_in),
    .node_ready(node_ready), .node_out(node_out), .out_data(out_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] relu(input logic [15:0] x);
`ifdef LAYER_SEQUENCER_RELU_EN
    return x[15] ? 16'h0000 : x;
`else
    return x;
`endif
  endfunction

  function automatic logic [255:0] rnd_vec();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // one transaction; gap>0 also checks cycles from previous done to node_start
  task automatic run_txn(input string tag, input bit hold, input int gap);
    int           wc, c, done_c, ns_cnt, mx;
    bit           all, in_ok, r;
    logic [255:0] exp_in;
    logic [63:0]  exp_out;
    bit           exp_err;
    int           exp_done;
    // reference: done one cycle after the latest first-ready, or timeout after TO wait cycles
    all = 1; mx = 0;
    for (int i = 0; i < 4; i++) begin
      if (fr[i] == 0 || fr[i] > TO) all = 0;
      else if (fr[i] > mx) mx = fr[i];
    end
    exp_err  = !all;
    exp_done = all ? mx + 1 : TO + 1;
    for (int i = 0; i < 4; i++)
      exp_out[i*16 +: 16] = (fr[i] != 0 && fr[i] <= TO) ? relu(v[i]) : 16'h0000;

    start = 1'b1;
    wc = 0;
    while (1) begin
      @(negedge clock);
      wc++;
      if (gap > 0 && wc == 1) begin
        chk({tag, "_done_pulse"}, done, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
      end
      if (node_start === 1'b1 || wc > 8) break;
      in_data = rnd_vec();
    end
    chk({tag, "_launch"}, node_start, 1'b1);
    if (node_start !== 1'b1) return;
    if (gap > 0) chk({tag, "_gap"}, wc, gap);
    exp_in = in_data;
    chk({tag, "_node_in"}, node_in, exp_in);
    chk({tag, "_busy"}, busy, 1'b1);
    if (!hold) start = 1'b0;

    c = 0; ns_cnt = 1; in_ok = 1; done_c = -1;
    while (c <= TO + 4) begin
      for (int i = 0; i < 4; i++) begin
        r = (fr[i] != 0 && c >= fr[i] && c < fr[i] + hl[i]);
        node_ready[i] = r;
        node_out[i]   = r ? 16'(v[i] + 16'(c - fr[i]) * 16'd17) : 16'($urandom);
      end
      if (rep_off != 0 && c == rep_off) begin
        node_ready[0] = 1'b1;
        node_out[0]   = rep_v;
      end
      in_data = rnd_vec();
      @(negedge clock);
      c++;
      if (node_start) ns_cnt++;
      if (node_in !== exp_in) in_ok = 0;
      if (done === 1'b1) begin
        done_c = c;
        break;
      end
    end
    node_ready = '0;
    chk({tag, "_done_cycle"}, done_c, exp_done);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_out_data"}, out_data, exp_out);
    chk({tag, "_busy_done"}, busy, 1'b1);
    chk({tag, "_one_launch"}, ns_cnt, 1);
    chk({tag, "_node_in_stable"}, in_ok, 1'b1);
  endtask

  task automatic set_sched(input int f0, f1, f2, f3, input logic [15:0] a, b, cc, d);
    fr = '{f0, f1, f2, f3};
    v  = '{a, b, cc, d};
    hl = '{1, 1, 1, 1};
    rep_off = 0;
    rep_v   = 16'h0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; in_data = '0; node_ready = '0; node_out = '0;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_node_start", node_start, 1'b0);
    chk("rst_out_data", out_data, 64'h0);
    chk("rst_node_in", node_in, 256'h0);
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);

    in_data = rnd_vec();
    set_sched(18, 18, 18, 18, 16'h0100, 16'h0280, 16'hFF00, 16'h0040);
    run_txn("basic", 1'b0, 0);

    // node 0 re-pulses with 0x7FFF; last ready lands on the terminal count
    set_sched(5, 9, 9, 20, 16'h1234, 16'h8001, 16'h0555, 16'hC000);
    rep_off = 12; rep_v = 16'h7FFF;
    run_txn("stagger", 1'b0, 2);

    set_sched(3, 7, 0, 10, 16'h0011, 16'h0022, 16'h0033, 16'hFFFF);
    run_txn("timeout", 1'b0, 2);

    set_sched(2, 2, 2, 2, 16'h1111, 16'h2222, 16'h3333, 16'h4444);
    run_txn("clear_err", 1'b0, 2);

    // held ready with changing values: first value sticks
    set_sched(4, 6, 1, 3, 16'h8888, 16'h0707, 16'h0001, 16'h7000);
    hl = '{5, 3, 4, 2};
    run_txn("held_rdy", 1'b0, 2);

    for (int t = 0; t < 3; t++) begin
      set_sched($urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12), $urandom_range(1, 12),
                16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      run_txn("held_start", 1'b1, 2);
    end
    start = 1'b0;

    // reset in the middle of WAIT, then stale ready pulses
    @(negedge clock);
    start = 1'b1;
    in_data = rnd_vec();
    for (int k = 0; k < 6 && node_start !== 1'b1; k++) @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_busy", busy, 1'b0);
    chk("rstw_done", done, 1'b0);
    chk("rstw_error", error, 1'b0);
    chk("rstw_node_start", node_start, 1'b0);
    chk("rstw_out_data", out_data, 64'h0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      node_ready = 4'hF;
      node_out   = {16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD};
      @(negedge clock);
    end
    node_ready = '0;
    chk("rstw_stale_busy", busy, 1'b0);
    chk("rstw_stale_out", out_data, 64'h0);
    set_sched(6, 2, 8, 4, 16'h0F0F, 16'hF0F0, 16'h0101, 16'h9999);
    run_txn("after_rst", 1'b0, 0);

    // randomized schedules, including never-ready and late-ready nodes
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 4; i++) begin
        fr[i] = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, TO + 3);
        hl[i] = $urandom_range(1, 3);
        v[i]  = 16'($urandom);
      end
      rep_off = (fr[0] != 0 && $urandom_range(0, 1) == 1) ? fr[0] + hl[0] + $urandom_range(0, 3) : 0;
      rep_v   = 16'($urandom);
      run_txn("rand", $urandom_range(0, 1) == 1, 2);
    end
    start = 1'b0;
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
